vga_vblank_scheduler: RTL

- Shares one display-side resource (sprite/tile RAM write port, palette registers) among NUM_REQ game-logic requesters.
- Access is granted only during vertical blanking, so the pixel path that feeds the VGA controller's RGB inputs owns the resource for the whole active display.
- Sits beside the VGA controller and consumes its ycoor output.
- Arbitration is round-robin, with a per-grant cycle budget and a frame counter/tick for game timing.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/vga_vblank_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the vblank scheduler state encoding.
// The timing generator and the scheduler both import this package.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = 800;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = 525;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_DISPLAY   = 2'd0;
    localparam sched_state_t ST_ARBITRATE = 2'd1;
    localparam sched_state_t ST_GRANTED   = 2'd2;
    localparam sched_state_t ST_CLOSED    = 2'd3;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index after ptr, wrapping
// modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && eligible[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/vga_vblank_scheduler.sv
// Grants a shared display-side resource to one requester at a time, only
// during vertical blanking, round-robin with a per-grant cycle budget.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DISPLAY   | active video; pixel path owns the resource, wait for vblank
// ARBITRATE | vblank open, pick next unserved requester
// GRANTED   | one owner holds gnt until release or budget expiry
// CLOSED    | guard zone reached or everyone served; wait for next frame
module vga_vblank_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int V_ACTIVE         = VGA_V_ACTIVE,
    parameter int V_TOTAL          = VGA_V_TOTAL,
    parameter int GUARD_LINES      = 5,
    parameter int MAX_GRANT_CYCLES = 1024,
    parameter int FRAME_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [9:0]             ycoor,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   gnt_valid,
    output logic                   vblank_window,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_GRANT_CYCLES);
    localparam logic [9:0]    Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    Y_GUARD  = 10'(V_TOTAL - GUARD_LINES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_GRANT_CYCLES - 1);

    sched_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     served_q, served_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FRAME_CNT_W-1:0] fc_q, fc_d;
    logic                   tick_q, tick_d;
    logic                   tout_q, tout_d;
    logic                   gnt_valid_q;
    logic                   vblank_q;
    logic [9:0]             prev_y;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     pick;
    logic                   pick_valid;
    logic                   owner_rel;

    assign eligible  = req & ~served_q;
    assign owner_rel = |(gnt_q & (done | ~req));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        served_d = served_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        fc_d     = fc_q;
        tick_d   = 1'b0;
        tout_d   = 1'b0;

        if (!enable) begin
            state_d  = ST_DISPLAY;
            gnt_d    = '0;
            served_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_DISPLAY: begin
                    if (ycoor == Y_ACT && prev_y != Y_ACT) begin
                        tick_d   = 1'b1;
                        fc_d     = fc_q + FRAME_CNT_W'(1);
                        served_d = '0;
                        state_d  = ST_ARBITRATE;
                    end
                end
                ST_ARBITRATE: begin
                    // Below V_ACTIVE means the frame wrapped under a long grant.
                    if (ycoor >= Y_GUARD || ycoor < Y_ACT || &served_q) begin
                        state_d = ST_CLOSED;
                    end else if (pick_valid) begin
                        gnt_d   = pick;
                        cnt_d   = '0;
                        state_d = ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    cnt_d = cnt_q + CW'(1);
                    if (owner_rel || cnt_q == CNT_LAST) begin
                        tout_d   = !owner_rel;
                        gnt_d    = '0;
                        served_d = served_q | gnt_q;
                        ptr_d    = PW'(onehot_idx(8'(gnt_q)));
                        state_d  = ST_ARBITRATE;
                    end
                end
                ST_CLOSED: begin
                    gnt_d = '0;
                    if (ycoor < Y_ACT) state_d = ST_DISPLAY;
                end
                default: begin
                    gnt_d   = '0;
                    state_d = ST_DISPLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DISPLAY;
            gnt_q       <= '0;
            served_q    <= '0;
            ptr_q       <= PW'(NUM_REQ - 1);
            cnt_q       <= '0;
            fc_q        <= '0;
            tick_q      <= 1'b0;
            tout_q      <= 1'b0;
            gnt_valid_q <= 1'b0;
            vblank_q    <= 1'b0;
            prev_y      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            served_q    <= served_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            fc_q        <= fc_d;
            tick_q      <= tick_d;
            tout_q      <= tout_d;
            gnt_valid_q <= |gnt_d;
            vblank_q    <= (state_d == ST_ARBITRATE) || (state_d == ST_GRANTED);
            prev_y      <= ycoor;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_valid     = gnt_valid_q;
    assign vblank_window = vblank_q;
    assign frame_tick    = tick_q;
    assign frame_count   = fc_q;
    assign timeout_err   = tout_q;

endmodule
